// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among N_REQ byte-stream requesters.
// Frames are timed locally because uart_tx has no busy output.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FRAME_BITS   = 10,
    parameter int unsigned GAP_CLKS     = 0
) (
    input  logic               clk_i,
    input  logic               srst_i,
    input  logic [N_REQ-1:0]   req_valid_i,
    input  logic [8*N_REQ-1:0] req_data_i,
    input  logic [N_REQ-1:0]   req_last_i,
    output logic [N_REQ-1:0]   req_ready_o,
    output logic               tx_start_o,
    output logic [7:0]         tx_data_o,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o
);

    localparam int unsigned FrameClks = CLKS_PER_BIT * FRAME_BITS + GAP_CLKS;
    localparam int unsigned CntW      = (FrameClks > 2) ? $clog2(FrameClks) : 1;
    localparam int unsigned PtrW      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(FrameClks - 1);
    localparam logic [PtrW-1:0] PtrRst  = PtrW'(N_REQ - 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [PtrW-1:0]   ptr_q;
    logic              lock_q;
    logic              start_q;
    logic [7:0]        data_q;
    logic [N_REQ-1:0]  grant_q;

    logic [N_REQ-1:0]  own_oh;
    logic [N_REQ-1:0]  hi_mask;
    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  pick;
    logic [N_REQ-1:0]  win_oh;
    logic [PtrW-1:0]   win;
    logic [7:0]        win_data;
    logic              win_last;
    logic              accept;

    // Requesters above the pointer take priority; wrap to the lowest valid otherwise.
    always_comb begin
        own_oh   = '0;
        hi_mask  = '0;
        win_oh   = '0;
        win      = '0;
        win_data = 8'h00;
        win_last = 1'b1;
        for (int i = 0; i < int'(N_REQ); i++) begin
            own_oh[i]  = (PtrW'(i) == ptr_q);
            hi_mask[i] = (PtrW'(i) > ptr_q);
        end
        elig = lock_q ? (req_valid_i & own_oh) : req_valid_i;
        pick = elig & hi_mask;
        if (pick == '0) begin
            pick = elig;
        end
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            if (pick[i]) begin
                win = PtrW'(i);
            end
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (PtrW'(i) == win) begin
                win_oh[i] = 1'b1;
                win_data  = req_data_i[8*i +: 8];
                win_last  = req_last_i[i];
            end
        end
        req_ready_o = '0;
        if (state_q == StIdle && !srst_i) begin
            req_ready_o = win_oh & elig;
        end
        accept = |req_ready_o;
    end

    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= PtrRst;
            lock_q  <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            grant_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        data_q  <= win_data;
                        grant_q <= win_oh;
                        ptr_q   <= win;
                        lock_q  <= ~win_last;
                        start_q <= 1'b1;
                        state_q <= StStart;
                    end else if (lock_q) begin
                        // Owner went away mid-packet: release so others can be served.
                        lock_q <= 1'b0;
                    end
                end
                StStart: begin
                    start_q <= 1'b0;
                    cnt_q   <= CntLoad;
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                        grant_q <= '0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_start_o = start_q;
    assign tx_data_o  = data_q;
    assign grant_o    = grant_q;
    assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester queues drive the DUT, a monitor
// checks every start pulse against hand-computed expected grant/data/spacing.
module tb_uart_tx_arbiter;

    localparam int N = 4;

    logic          clk  = 1'b0;
    logic          srst = 1'b1;
    logic [N-1:0]  req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]  req_last  = '0;
    logic [N-1:0]  req_ready;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic [N-1:0]  grant;
    logic          busy;

    uart_tx_arbiter #(
        .N_REQ       (4),
        .CLKS_PER_BIT(4),
        .FRAME_BITS  (10),
        .GAP_CLKS    (2)
    ) dut (
        .clk_i      (clk),
        .srst_i     (srst),
        .req_valid_i(req_valid),
        .req_data_i (req_data),
        .req_last_i (req_last),
        .req_ready_o(req_ready),
        .tx_start_o (tx_start),
        .tx_data_o  (tx_data),
        .grant_o    (grant),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] grant;
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_start = 0;
    bit   have_last  = 0;

    logic [8:0] mem [N][16];
    int         head [N] = '{default: 0};
    int         tail [N] = '{default: 0};
    logic [N-1:0] acc = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic bit pending();
        for (int k = 0; k < N; k++) begin
            if (head[k] != tail[k]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic push(input int k, input logic [7:0] d, input logic l);
        mem[k][tail[k]] = {l, d};
        tail[k] = tail[k] + 1;
    endtask

    task automatic exp_push(input logic [3:0] g, input logic [7:0] d, input int gap);
        exp_t e;
        e.grant = g;
        e.data  = d;
        e.gap   = gap;
        exp_q.push_back(e);
    endtask

    // Handshake seen mid-cycle completes at the following rising edge.
    always @(negedge clk) acc = req_ready & req_valid;

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k] && head[k] != tail[k]) head[k] = head[k] + 1;
            if (head[k] != tail[k]) begin
                req_valid[k]      = 1'b1;
                req_data[8*k +: 8] = mem[k][head[k]][7:0];
                req_last[k]       = mem[k][head[k]][8];
            end else begin
                req_valid[k]      = 1'b0;
                req_data[8*k +: 8] = 8'hEE;
                req_last[k]       = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (srst) begin
            have_last = 0;
        end else begin
            if (busy) chk("ready_while_busy", 32'(req_ready), 32'd0);
            if (tx_start) begin
                chk("start_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    chk("tx_grant", 32'(grant), 32'(mon_e.grant));
                    chk("tx_data", 32'(tx_data), 32'(mon_e.data));
                    if (mon_e.gap != 0 && have_last)
                        chk("start_gap", 32'(cyc - last_start), 32'(mon_e.gap));
                end
                last_start = cyc;
                have_last  = 1;
            end
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, 32'(tx_start), 32'd0);
        chk({tag, "_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        srst = 1'b1;
        repeat (2) @(negedge clk);
        srst = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy || pending()) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(n < 2000), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int n_r;
        int n_s;
        int n_b;

        repeat (2) @(negedge clk);
        chk_zero("por");
        srst = 1'b0;
        @(negedge clk);

        // Single byte from req0.
        exp_push(4'b0001, 8'hA5, 0);
        push(0, 8'hA5, 1'b1);
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        chk("t1_start", 32'(tx_start), 32'd1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t1_busy_cycles", 32'(n), 32'd43);
        chk("t1_grant_idle", 32'(grant), 32'd0);
        chk("t1_data_held", 32'(tx_data), 32'hA5);

        // All four valid: round-robin 0,1,2,3,0 at 44-cycle spacing.
        do_reset();
        exp_push(4'b0001, 8'hA0, 0);
        exp_push(4'b0010, 8'hB0, 44);
        exp_push(4'b0100, 8'hC0, 44);
        exp_push(4'b1000, 8'hD0, 44);
        exp_push(4'b0001, 8'hA1, 44);
        push(0, 8'hA0, 1'b1);
        push(0, 8'hA1, 1'b1);
        push(1, 8'hB0, 1'b1);
        push(2, 8'hC0, 1'b1);
        push(3, 8'hD0, 1'b1);
        wait_idle("t2_done");

        // Packet lock on req2 while others wait.
        exp_push(4'b0100, 8'h11, 0);
        exp_push(4'b0100, 8'h22, 44);
        exp_push(4'b0100, 8'h33, 44);
        exp_push(4'b1000, 8'h3C, 44);
        exp_push(4'b0001, 8'h01, 44);
        exp_push(4'b0010, 8'h0A, 44);
        exp_push(4'b0001, 8'h02, 44);
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b1);
        @(negedge clk);
        chk("t3_first_ready", 32'(req_ready), 32'b0100);
        push(0, 8'h01, 1'b1);
        push(0, 8'h02, 1'b1);
        push(1, 8'h0A, 1'b1);
        push(3, 8'h3C, 1'b1);
        wait_idle("t3_done");

        // Lock dropped by req1: one idle cycle to release, then req3.
        exp_push(4'b0010, 8'h41, 0);
        exp_push(4'b1000, 8'h43, 45);
        push(1, 8'h41, 1'b0);
        push(3, 8'h43, 1'b1);
        wait_idle("t4_done");

        // Reset in WAIT with counter at 20.
        exp_push(4'b0001, 8'h5A, 0);
        push(0, 8'h5A, 1'b1);
        n = 0;
        while (!tx_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t5_start_seen", 32'(n < 50), 32'd1);
        repeat (22) @(negedge clk);
        #2 srst = 1'b1;
        #1 chk_zero("t5_async_rst");
        exp_push(4'b0001, 8'h66, 0);
        exp_push(4'b0010, 8'h77, 44);
        push(1, 8'h77, 1'b1);
        push(0, 8'h66, 1'b1);
        @(negedge clk);
        @(negedge clk);
        srst = 1'b0;
        wait_idle("t5_done");

        // No requesters.
        n_r = 0;
        n_s = 0;
        n_b = 0;
        repeat (100) begin
            @(negedge clk);
            if (|req_ready) n_r++;
            if (tx_start) n_s++;
            if (busy) n_b++;
        end
        chk("t6_ready_cnt", 32'(n_r), 32'd0);
        chk("t6_start_cnt", 32'(n_s), 32'd0);
        chk("t6_busy_cnt", 32'(n_b), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_tx transmitter among N byte-stream requesters.
- Accepts bytes over per-requester valid/ready handshakes.
- Issues one-cycle start pulses and data to uart_tx.
- Uart_tx has no busy output, so the arbiter times each frame itself with a counter before starting the next byte.
- Optional packet lock lets a requester send a multi-byte message without interleaving.
- Sits between the requesters (command/response logic) and uart_tx; replaces the button-driven start path.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CLKS_PER_BIT, 868, clock cycles per UART bit; must match uart_tx.
- FRAME_BITS, 10, bits per frame (start + 8 data + stop).
- GAP_CLKS, 0, extra idle cycles inserted after each frame.

Ports:
- clk_i  in  1  system clock.
- srst_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  N_REQ  per-requester byte valid.
- req_data_i  in  8*N_REQ  per-requester byte; requester k uses bits [8k+7:8k].
- req_last_i  in  N_REQ  byte is the final byte of the packet; 0 requests lock.
- req_ready_o  out  N_REQ  byte accepted this cycle (one-hot or zero).
- tx_start_o  out  1  one-cycle start pulse to uart_tx tr_but_i.
- tx_data_o  out  8  byte to uart_tx data_i; held stable until the next start.
- grant_o  out  N_REQ  one-hot owner of the byte currently in flight; 0 when idle.
- busy_o  out  1  high in START and WAIT.

Behaviour:
- Reset (asynchronous, any state):
  - State = IDLE, counter = 0.
  - tx_start_o = 0, tx_data_o = 0, grant_o = 0, busy_o = 0, req_ready_o = 0.
  - lock = 0, last-grant pointer = N_REQ-1, so requester 0 has first priority.
  - Reset mid-frame aborts timing; the frame already inside uart_tx is not recalled.
- FRAME_CLKS = CLKS_PER_BIT*FRAME_BITS + GAP_CLKS.
- States: IDLE, START, WAIT.
- IDLE, lock = 0:
  - Winner = first requester with valid = 1, searching from pointer+1 upward with wrap-around.
  - req_ready_o[winner] = 1, combinationally, in the same cycle; the transfer completes at that edge.
  - Registered at the edge: byte captured into tx_data_o, grant_o = onehot(winner), pointer = winner, lock = ~req_last_i[winner].
  - Next state = START.
  - No valid requester: stay in IDLE, all req_ready_o = 0.
- IDLE, lock = 1:
  - Only the owner is eligible; its handshake is handled as above.
  - If the owner is not valid, lock is cleared this cycle and normal arbitration resumes next cycle.
- START: tx_start_o = 1 for exactly one cycle; counter loaded with FRAME_CLKS-1; next state = WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When counter = 0, next state = IDLE and grant_o is cleared; pointer and lock are kept.
- Latency and throughput:
  - Accept edge to tx_start_o high: 1 cycle.
  - Back-to-back bytes: one accept per FRAME_CLKS+2 cycles.
- req_ready_o is never asserted outside IDLE; holding valid high during START/WAIT is legal and has no effect.
- Fairness: after any unlocked grant, every other valid requester is served before the same requester is served again.
- req_last_i is sampled only on the accepted byte. A lock with req_last_i = 1 on the first byte is a single-byte packet and releases immediately.
- Data/last from non-selected requesters are ignored.

Test Plan:
(N_REQ=4, CLKS_PER_BIT=4, FRAME_BITS=10, GAP_CLKS=2, so FRAME_CLKS=42.)
1. Single byte: req0 valid, data 0xA5, last=1 → ready_o=0001 in the same cycle; tx_start_o=1 and tx_data_o=0xA5 on the next cycle; busy_o high for 43 cycles; return to IDLE.
2. All four valid, last=1, held → grant order 0,1,2,3,0. Start pulses spaced exactly 44 cycles apart.
3. Lock: req2 sends 0x11 (last=0), 0x22 (last=0), 0x33 (last=1) while req0/req1 stay valid → tx_data sequence 11,22,33, then req3 (if valid) or req0.
4. Lock drop: req1 sends last=0, then deasserts valid; req3 valid → lock clears in IDLE, req3 granted one cycle later.
5. Reset mid-WAIT (counter=20) → all outputs 0 immediately; after release, req0 wins first with pointer reset.
6. No requesters for 100 cycles → no ready_o, no start pulse, busy_o = 0 throughout.
